// File: rtl/spi_share_arb.sv
// spi_share_arb: round-robin arbiter plus a single serial engine that shares
// one sclk/sdo/sdi shift bus between N word requesters. Each slave has its
// own lock (latch strobe) line.
//
// Optional build macro SPI_ARB_READBACK_CHECK_EN: keeps the word each channel
// sent on its previous completed transfer and compares it with the word
// received on the current one (slaves echo their previously latched word).
// Without the macro err is tied low and no comparison storage exists.
//
// Handshake: req[k] is a level. The requester raises it and holds it, with
// data[k] stable, until done[k] pulses for one cycle. data[k] is captured in
// LOAD, so later changes only affect the next transfer. A req still high
// after done is simply arbitrated again; dropping req mid-transfer does not
// cancel that transfer.
module spi_share_arb #(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 18
) (
  input  logic                   clk,
  input  logic                   aclr_n,
  input  logic                   sclr,
  input  logic [N-1:0]           req,
  input  logic [N*WIDTH-1:0]     data,
  output logic [N-1:0]           done,
  output logic [N*WIDTH-1:0]     data_old,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   ch,
  output logic [N-1:0]           err,
  output logic                   sclk,
  output logic                   sdo,
  input  logic                   sdi,
  output logic [N-1:0]           lock
);

  localparam int CW    = $clog2(N);
  localparam int CNT_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      ch_q, ch_d;
  logic [CW-1:0]      last_q, last_d;
  logic [CW-1:0]      cand, pick;
  logic               pick_vld;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   tx_q, tx_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic [N*WIDTH-1:0] dold_q, dold_d;
  logic               xfer_done;

  // Round-robin pick: first requesting channel at or above last_served+1, wrapping.
  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = CW'((int'(last_q) + i) % N);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and bus outputs; all lines default low.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    last_d    = last_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dold_d    = dold_q;
    sclk      = 1'b0;
    sdo       = 1'b0;
    lock      = '0;
    done      = '0;
    xfer_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          ch_d    = pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_d    = data[ch_q*WIDTH +: WIDTH];
        bit_d   = BIT_W'(WIDTH - 1);
        div_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Low half drives the bit, high half holds it while the slave samples.
        sclk = (div_q >= CNT_W'(CLK_DIV));
        sdo  = tx_q[WIDTH-1];
        if (div_q == CNT_W'(CLK_DIV)) begin
          rx_d = {rx_q[WIDTH-2:0], sdi};
        end
        if (div_q == CNT_W'(2 * CLK_DIV - 1)) begin
          div_d = '0;
          tx_d  = {tx_q[WIDTH-2:0], 1'b0};
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      LATCH: begin
        lock[ch_q] = 1'b1;
        if (div_q == CNT_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = GAP;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (div_q == CNT_W'(CLK_DIV - 1)) begin
          done[ch_q]                  = 1'b1;
          xfer_done                   = 1'b1;
          dold_d[ch_q*WIDTH +: WIDTH] = rx_q;
          last_d                      = ch_q;
          div_d                       = '0;
          state_d                     = IDLE;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; sclr aborts like reset but keeps the last received words.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      last_q  <= CW'(N - 1);
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dold_q  <= '0;
    end else if (sclr) begin
      state_q <= IDLE;
      ch_q    <= '0;
      last_q  <= CW'(N - 1);
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dold_q  <= dold_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign ch       = ch_q;
  assign data_old = dold_q;

`ifdef SPI_ARB_READBACK_CHECK_EN
  logic [WIDTH-1:0]   sent_q;
  logic [N*WIDTH-1:0] prev_q;
  logic [N-1:0]       prev_vld_q;
  logic [N-1:0]       err_q;

  // Echo check: the received word must equal what this channel sent last time.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      sent_q     <= '0;
      prev_q     <= '0;
      prev_vld_q <= '0;
      err_q      <= '0;
    end else if (sclr) begin
      prev_vld_q <= '0;
      err_q      <= '0;
    end else begin
      if (state_q == LOAD) begin
        sent_q <= data[ch_q*WIDTH +: WIDTH];
      end
      if (xfer_done) begin
        err_q[ch_q]                 <= prev_vld_q[ch_q] &&
                                       (rx_q != prev_q[ch_q*WIDTH +: WIDTH]);
        prev_q[ch_q*WIDTH +: WIDTH] <= sent_q;
        prev_vld_q[ch_q]            <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_spi_share_arb.sv
// tb_spi_share_arb: directed bench for spi_share_arb (N=4, WIDTH=16, CLK_DIV=2).
// A transfer-level model predicts every output each cycle from the cycle
// offset since arbitration; directed scenarios pin timing and data literally.
module tb_spi_share_arb;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CD = 2;
  localparam int SH_LAST = 1 + 2 * CD * W;   // last SHIFT offset
  localparam int LT_LAST = SH_LAST + CD;     // last LATCH offset
  localparam int DONE_K  = LT_LAST + CD;     // done offset (=1+2*CD*(W+1))

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           aclr_n;
  logic           sclr;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   done;
  logic [N*W-1:0] data_old;
  logic           busy;
  logic [1:0]     ch;
  logic [N-1:0]   err;
  logic           sclk;
  logic           sdo;
  logic           sdi;
  logic [N-1:0]   lock;

  always #5 clk = ~clk;

  spi_share_arb #(.N(N), .WIDTH(W), .CLK_DIV(CD)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .req(req), .data(data),
    .done(done), .data_old(data_old), .busy(busy), .ch(ch), .err(err),
    .sclk(sclk), .sdo(sdo), .sdi(sdi), .lock(lock)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sdi: sdo delayed by one sclk period (2*CD clocks), or forced high.
  int         sdi_mode;
  logic [3:0] hist;
  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) hist <= '0;
    else         hist <= {hist[2:0], sdo};
  end
  assign sdi = (sdi_mode == 1) ? 1'b1 : hist[3];

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transfer-level model ----------------
  logic           m_busy;
  int             m_k;
  logic [1:0]     m_ch;
  int             m_last;
  logic [W-1:0]   m_word, m_rx;
  logic [N*W-1:0] m_dold;
  logic [N-1:0]   m_err, m_pv;
  logic [W-1:0]   m_prev [N];

  task automatic model_reset(input bit keep_dold);
    m_busy = 1'b0;
    m_k    = 0;
    m_ch   = '0;
    m_last = N - 1;
    m_err  = '0;
    m_pv   = '0;
    if (!keep_dold) m_dold = '0;
  endtask

  initial model_reset(1'b0);

  always @(negedge clk) begin : model_cmp
    logic [N-1:0] e_lock, e_done;
    logic         e_sclk, e_sdo;
    int           bi, ph, idx;
    bit           found;
    if (!aclr_n) model_reset(1'b0);
    e_lock = '0; e_done = '0; e_sclk = 1'b0; e_sdo = 1'b0; bi = 0; ph = 0;
    if (m_busy && m_k >= 2 && m_k <= SH_LAST) begin
      bi     = (m_k - 2) / (2 * CD);
      ph     = (m_k - 2) % (2 * CD);
      e_sclk = (ph >= CD);
      e_sdo  = m_word[W-1-bi];
    end
    if (m_busy && m_k > SH_LAST && m_k <= LT_LAST) e_lock[m_ch] = 1'b1;
    if (m_busy && m_k == DONE_K) e_done[m_ch] = 1'b1;

    check("busy", busy, m_busy);
    check("sclk", sclk, e_sclk);
    check("sdo", sdo, e_sdo);
    check("lock", lock, e_lock);
    check("done", done, e_done);
    check("data_old", data_old, m_dold);
    check("err", err, m_err);
    if (m_busy) check("ch", ch, m_ch);
    check("lock_onehot", ($countones(lock) <= 1), 1'b1);
    check("lock_vs_sclk", (lock != '0) && sclk, 1'b0);

    // advance model to the next cycle
    if (aclr_n) begin
      if (sclr) begin
        model_reset(1'b1);
      end else if (!m_busy) begin
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
          idx = (m_last + i) % N;
          if (!found && req[idx]) begin
            found  = 1'b1;
            m_ch   = 2'(idx);
            m_busy = 1'b1;
            m_k    = 1;
          end
        end
      end else begin
        if (m_k == 1) begin
          m_word = data[m_ch*W +: W];
          m_rx   = '0;
        end
        if (m_k >= 2 && m_k <= SH_LAST && ((m_k - 2) % (2 * CD)) == CD)
          m_rx = {m_rx[W-2:0], sdi};
        if (m_k == DONE_K) begin
          m_dold[m_ch*W +: W] = m_rx;
`ifdef SPI_ARB_READBACK_CHECK_EN
          m_err[m_ch]  = m_pv[m_ch] && (m_rx != m_prev[m_ch]);
          m_prev[m_ch] = m_word;
          m_pv[m_ch]   = 1'b1;
`endif
          m_last = m_ch;
          m_busy = 1'b0;
        end else begin
          m_k++;
        end
      end
    end
  end

  // ---------------- event monitor for directed checks ----------------
  int           done_cnt [N];
  int           done_cyc [N];
  bit           done_seen [N];
  int           lock_cnt [N];
  int           lock_first [N];
  int           lock_last [N];
  int           order_q [$];
  logic [W-1:0] cap_word;
  int           sclk_pulses;
  logic         sclk_prev = 1'b0;

  task automatic clr_mon();
    for (int c = 0; c < N; c++) begin
      done_cnt[c] = 0; done_cyc[c] = -1; done_seen[c] = 0;
      lock_cnt[c] = 0; lock_first[c] = -1; lock_last[c] = -1;
    end
    order_q.delete();
    cap_word    = '0;
    sclk_pulses = 0;
  endtask

  always @(negedge clk) begin
    if (sclk && !sclk_prev) begin
      cap_word = {cap_word[W-2:0], sdo};
      sclk_pulses++;
    end
    sclk_prev = sclk;
    for (int c = 0; c < N; c++) begin
      if (done[c]) begin
        done_cnt[c]++; done_cyc[c] = cyc; done_seen[c] = 1; order_q.push_back(c);
      end
      if (lock[c]) begin
        if (lock_cnt[c] == 0) lock_first[c] = cyc;
        lock_last[c] = cyc;
        lock_cnt[c]++;
      end
    end
  end

  task automatic wait_done(input int c, input int bound);
    int n = 0;
    while (!done_seen[c] && n < bound) begin tick(); n++; end
    check("done_timeout", done_seen[c], 1'b1);
  endtask

  task automatic wait_count(input int k, input int bound);
    int n = 0;
    while (order_q.size() < k && n < bound) begin tick(); n++; end
    check("order_timeout", (order_q.size() >= k), 1'b1);
  endtask

  task automatic xfer(input int c, input logic [W-1:0] word, input int mode);
    sdi_mode      = mode;
    data[c*W +: W] = word;
    clr_mon();
    req[c] = 1'b1;
    wait_done(c, 200);
    req = '0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int t;
    int exp_order [8];
    logic [3:0] exp_err;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 0};
    aclr_n = 1'b0; sclr = 1'b0; req = '0; data = '0; sdi_mode = 0;
    clr_mon();

    // reset values
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_sdo", sdo, 1'b0);
    check("rst_lock", lock, '0);
    check("rst_done", done, '0);
    check("rst_ch", ch, '0);
    check("rst_dold", data_old, '0);
    check("rst_err", err, '0);
    aclr_n = 1'b1;
    clr_mon();
    repeat (10) tick();
    check("idle_sclk_pulses", sclk_pulses, 0);
    check("idle_busy", busy, 1'b0);

    // single transfer on ch1
    data[1*W +: W] = 16'h0824;
    clr_mon();
    req = 4'b0010;
    t = cyc;
    wait_done(1, 200);
    req = '0;
    repeat (5) tick();
    check("single_done_cyc", done_cyc[1], t + 69);
    check("single_done_cnt", done_cnt[1], 1);
    check("single_lock_first", lock_first[1], t + 66);
    check("single_lock_last", lock_last[1], t + 67);
    check("single_lock_cnt", lock_cnt[1], 2);
    check("single_other_locks", lock_cnt[0] + lock_cnt[2] + lock_cnt[3], 0);
    check("single_sdo_word", cap_word, 16'h0824);
    check("single_sclk_pulses", sclk_pulses, 16);
    check("single_dold1", data_old[1*W +: W], 16'h0412);

    // idle sclr: pointer back to ch0, data_old kept
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    check("sclr_keep_dold", data_old[1*W +: W], 16'h0412);
    check("sclr_busy", busy, 1'b0);

    // round robin
    data = {16'hA5A5, 16'h3C3C, 16'h00FF, 16'h1001};
    clr_mon();
    req = 4'b1111;
    wait_count(5, 500);
    wait_count(6, 200);
    req = 4'b0101;
    wait_count(8, 300);
    req = '0;
    for (int i = 0; i < 8; i++)
      check("rr_order", (order_q.size() > i) ? order_q[i] : -1, exp_order[i]);
    check("rr_dold3", data_old[3*W +: W], 16'h52D2);

    // abort on ch3 mid SHIFT
    data[3*W +: W] = 16'hBEEF;
    clr_mon();
    req = 4'b1000;
    repeat (30) tick();
    sclr = 1'b1;
    req  = '0;
    tick();
    sclr = 1'b0;
    check("abort_sclk", sclk, 1'b0);
    check("abort_lock", lock, '0);
    check("abort_busy", busy, 1'b0);
    repeat (80) tick();
    check("abort_no_done", done_cnt[3], 0);
    check("abort_dold3", data_old[3*W +: W], 16'h52D2);
    data[3*W +: W] = 16'h8001;
    clr_mon();
    req = 4'b1000;
    wait_done(3, 200);
    req = '0;
    check("restart_sdo_word", cap_word, 16'h8001);
    check("restart_pulses", sclk_pulses, 16);
    check("restart_dold3", data_old[3*W +: W], 16'h4000);

    // async reset while lock[2] is high
    data[2*W +: W] = 16'h1357;
    repeat (2) tick();
    clr_mon();
    req = 4'b0100;
    t = cyc;
    repeat (66) tick();
    check("latch_lock2", lock, 4'b0100);
    aclr_n = 1'b0;
    #1;
    check("areset_lock", lock, '0);
    check("areset_busy", busy, 1'b0);
    tick();
    aclr_n = 1'b1;
    req    = '0;
    check("areset_dold", data_old, '0);
    repeat (3) tick();
    check("areset_no_done", done_cnt[2], 0);

    // readback sequence on ch0
`ifdef SPI_ARB_READBACK_CHECK_EN
    exp_err = 4'b0100;
`else
    exp_err = 4'b0000;
`endif
    xfer(0, 16'hFFFF, 1);
    tick();
    check("rb_t1_err0", err[0], exp_err[0]);
    xfer(0, 16'h1234, 1);
    tick();
    check("rb_t2_err0", err[0], exp_err[1]);
    xfer(0, 16'hFFFF, 0);
    tick();
    check("rb_t3_err0", err[0], exp_err[2]);
    check("rb_t3_dold0", data_old[0 +: W], 16'h7FFF);
    xfer(0, 16'h0000, 1);
    tick();
    check("rb_t4_err0", err[0], exp_err[3]);
    check("rb_t4_dold0", data_old[0 +: W], 16'hFFFF);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_share_arb.md
Name: spi_share_arb

Overview:
- Round-robin arbiter and serial engine that shares one SPI-style shift bus (sclk/sdo/sdi) between N 16-bit word requesters, e.g. generator control, pult indicators and future slaves.
- Each slave has its own lock (latch strobe) line; sclk/sdo/sdi are common.
- Sits between the ctrl-bus register file (requesters) and the board serial pins.
- Replaces per-slave free-running shifters with one scheduled engine.

Parameters:
N, 4, number of requesters/slaves (2..8)
WIDTH, 16, bits per transfer
CLK_DIV, 18, clk cycles per sclk half-period (>=1)

Ports:
clk  in  1  system clock
aclr_n  in  1  asynchronous active-low reset
sclr  in  1  synchronous clear, active high
req  in  N  per-channel request, level; held until done
data  in  N*WIDTH  per-channel word to send, channel k at [k*WIDTH +: WIDTH]
done  out  N  one-cycle completion pulse per channel
data_old  out  N*WIDTH  per-channel word captured from sdi on last completed transfer
busy  out  1  high in any state except IDLE
ch  out  $clog2(N)  channel being served; valid while busy
err  out  N  readback mismatch flags (see Optional Feature)
sclk  out  1  shared serial clock, idle low
sdo  out  1  shared serial data out, MSB first
sdi  in  1  shared serial data in
lock  out  N  per-slave latch strobe

Behaviour:
- Clock and reset: one clock, clk. Reset aclr_n is asynchronous, active-low.
- Reset values: sclk=0, sdo=0, lock=0, done=0, busy=0, ch=0, data_old=0, err=0, state=IDLE. RR pointer set so channel 0 has highest priority.
- sclr: same values as reset, except data_old is retained. Takes effect the next cycle from any state. An aborted transfer produces no done pulse and no data_old update.
- FSM states: IDLE, LOAD, SHIFT, LATCH, GAP.
- IDLE: if any req bit is set, pick the first set bit at or above (last_served+1) mod N, with wrap-around. Set ch, go to LOAD.
- LOAD (1 cycle): capture data[ch] into the shift register. Bit counter = WIDTH-1. Go to SHIFT.
- SHIFT: each bit lasts 2*CLK_DIV cycles.
  - Low half-period: sclk=0, sdo=current MSB.
  - High half-period: sclk=1; sdi is sampled on the cycle sclk rises and shifted into the receive register LSB.
  - Register shifts left at the end of each bit.
  - After WIDTH bits go to LATCH.
  - SHIFT lasts 2*CLK_DIV*WIDTH cycles.
- LATCH: lock[ch]=1 for CLK_DIV cycles; sclk=0, sdo=0.
- GAP: CLK_DIV cycles with all lines low.
  - In the last GAP cycle: done[ch]=1, data_old[ch] <= receive register, last_served <= ch.
  - Next state is IDLE.
- Latency: req seen in IDLE at cycle t gives done at t+1+2*CLK_DIV*(WIDTH+1).
- A channel still requesting after done is rearbitrated. Minimum 1 IDLE cycle between transfers.
- req dropped mid-transfer: the transfer completes normally.
- data[ch] changing after LOAD has no effect on the current transfer.
- Only one lock bit is high at a time. lock is never high while sclk toggles.

Optional Feature:
- Macro: SPI_ARB_READBACK_CHECK_EN.
- When defined: each channel keeps the word it sent on its previous completed transfer. Slaves echo their previously latched word.
  - At done, err[ch] <= (received word != previous sent word).
  - The first transfer on a channel after reset or sclr never sets err.
  - A later matching transfer clears err[ch].
- When undefined: err is tied to 0 and no comparison storage is built.

Test Plan:
Bench settings: N=4, WIDTH=16, CLK_DIV=2, sdi looped to sdo delayed by one sclk period unless stated.
- Reset: hold aclr_n=0 -> all outputs 0. Release with no req -> busy stays 0, sclk never toggles.
- Single transfer: req[1]=1, data[1]=0x0824 seen at t -> sdo carries 0x0824 MSB first over 16 sclk pulses; lock[1] high at t+66..t+67; done[1] pulses at t+69 only; data_old[1] = sampled word; lock[0,2,3] stay 0.
- Round-robin: req=4'b1111 held -> service order 0,1,2,3,0. Then after serving ch1 assert req=4'b0101 -> ch2 served before ch0.
- Abort: sclr pulse in the middle of SHIFT on ch3 -> next cycle sclk=0, lock=0, busy=0; no done[3]; data_old[3] unchanged; a subsequent req[3] restarts from bit 15.
- Async reset in LATCH: aclr_n low while lock[2]=1 -> lock[2]=0 and busy=0 immediately, without waiting for a clk edge.
- Readback (macro on): ch0 sends 0x1234, then 0x5678 with sdi returning 0x1234 -> err[0]=0. Third transfer with sdi forced to 0xFFFF -> err[0]=1 at done. Macro off -> err stays 0.
